// File: rtl/lcd_bus_writer_if.sv
// Upstream byte handshake plus the physical LCD pins of the 8080-style write engine.
// fsm_state exposes the writer's state register for observation only.
interface lcd_bus_writer_if;
  logic       i_valid;
  logic       o_ready;
  logic       i_rs;
  logic [7:0] i_data;
  logic       i_wait_fmark;
  logic       i_lcd_fmark;
  logic       o_lcd_wr;
  logic       o_lcd_rs;
  logic [7:0] o_lcd_data;
  logic       o_busy;
  logic       o_fmark_pulse;
  logic [2:0] fsm_state;

  // A byte is accepted on every clock edge where i_valid and o_ready are both high;
  // o_ready depends only on FIFO fullness, and i_rs/i_data/i_wait_fmark are read only then.
  modport master (
    output i_valid, i_rs, i_data, i_wait_fmark, i_lcd_fmark,
    input  o_ready, o_lcd_wr, o_lcd_rs, o_lcd_data, o_busy, o_fmark_pulse, fsm_state
  );

  modport slave (
    input  i_valid, i_rs, i_data, i_wait_fmark, i_lcd_fmark,
    output o_ready, o_lcd_wr, o_lcd_rs, o_lcd_data, o_busy, o_fmark_pulse, fsm_state
  );
endinterface

// File: rtl/lcd_bus_writer.sv
// Buffers command/data bytes in a small FIFO and emits each as one WR strobe with
// programmable low/high widths, optionally holding a byte until the next FMARK rise.
module lcd_bus_writer #(
  parameter int WR_LOW_CYCLES  = 2,
  parameter int WR_HIGH_CYCLES = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  lcd_bus_writer_if.slave bus
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int MAXC = (WR_LOW_CYCLES > WR_HIGH_CYCLES) ? WR_LOW_CYCLES : WR_HIGH_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] LOW_LAST  = CW'(WR_LOW_CYCLES - 1);
  localparam logic [CW-1:0] HIGH_LAST = CW'(WR_HIGH_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_FM = 3'd1,
    SETUP   = 3'd2,
    LOW     = 3'd3,
    HIGH    = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lcd_wr;
  logic          lcd_rs;
  logic [7:0]    lcd_data;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          push_en;
  logic          load;
  logic [9:0]    head;

  logic          fm_sync1;
  logic          fm_sync2;
  logic          fm_prev;
  logic          fmark_pulse;

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign push_en     = bus.i_valid & ~full;
  assign head        = mem[rd_ptr];
  assign fmark_pulse = fm_sync2 & ~fm_prev;

  // Pop happens only when the FSM loads a byte: from IDLE or on the last HIGH cycle.
  assign load = ~empty & ((state == IDLE) | ((state == HIGH) & (cnt == HIGH_LAST)));

  always_ff @(posedge i_clk) begin
    if (push_en) mem[wr_ptr] <= {bus.i_wait_fmark, bus.i_rs, bus.i_data};
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (load)    rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, load})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FMARK is asynchronous to i_clk: two sync flops, then a delay flop for edge detect.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fm_sync1 <= 1'b0;
      fm_sync2 <= 1'b0;
      fm_prev  <= 1'b0;
    end else begin
      fm_sync1 <= bus.i_lcd_fmark;
      fm_sync2 <= fm_sync1;
      fm_prev  <= fm_sync2;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      lcd_wr   <= 1'b1;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else if (load) begin
      lcd_rs   <= head[8];
      lcd_data <= head[7:0];
      lcd_wr   <= 1'b1;
      cnt      <= '0;
      state    <= head[9] ? WAIT_FM : SETUP;
    end else begin
      case (state)
        IDLE: begin
          lcd_wr <= 1'b1;
        end
        WAIT_FM: begin
          if (fmark_pulse) begin
            state  <= LOW;
            lcd_wr <= 1'b0;
            cnt    <= '0;
          end
        end
        SETUP: begin
          state  <= LOW;
          lcd_wr <= 1'b0;
          cnt    <= '0;
        end
        LOW: begin
          if (cnt == LOW_LAST) begin
            state  <= HIGH;
            lcd_wr <= 1'b1;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (cnt == HIGH_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          lcd_wr <= 1'b1;
          cnt    <= '0;
        end
      endcase
    end
  end

  assign bus.o_ready       = ~full;
  assign bus.o_busy        = (state != IDLE) | ~empty;
  assign bus.o_fmark_pulse = fmark_pulse;
  assign bus.o_lcd_wr      = lcd_wr;
  assign bus.o_lcd_rs      = lcd_rs;
  assign bus.o_lcd_data    = lcd_data;
  assign bus.fsm_state     = state;
endmodule
